// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared SEC-DED Hamming parameters, error classes and layout helpers
package hamming_pkg;

  typedef enum logic [1:0] {CLEAN, SINGLE, PARITY_ONLY, DOUBLE} err_class_e;

  // Smallest p with 2**p >= data_w + p + 1.
  function automatic int calc_par_w(input int data_w);
    int res;
    res = 0;
    for (int p = 1; p < 31; p++) begin
      if (res == 0 && (1 << p) >= data_w + p + 1) res = p;
    end
    return res;
  endfunction

  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // Codeword position of data bit k; data fills non-power-of-two slots from 3 upward.
  function automatic int data_pos(input int k);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 3; p < k + 40; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == k && pos == 0) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_syndrome_calc.sv
// rtl/hamming_syndrome_calc.sv - combinational syndrome and overall-parity check of a codeword
module hamming_syndrome_calc #(
  parameter int CODE_W = 32,
  parameter int PAR_W  = 5
) (
  input  logic [CODE_W-1:0] code,
  output logic [PAR_W-1:0]  syndrome,
  output logic              p_err
);

  always_comb begin
    syndrome = '0;
    for (int i = 1; i < CODE_W; i++) begin
      if (code[i]) syndrome = syndrome ^ PAR_W'(i);
    end
    p_err = ^code;
  end

endmodule

// File: rtl/hamming_secded_stream_decoder.sv
// rtl/hamming_secded_stream_decoder.sv - two-stage pipelined SEC-DED decoder on a valid/ready stream
module hamming_secded_stream_decoder
  import hamming_pkg::*;
#(
  parameter int  DATA_W = 26,
  parameter int  CNT_W  = 16,
  localparam int PAR_W  = calc_par_w(DATA_W),
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] code_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [PAR_W-1:0]  syndrome,
  output logic              err_single,
  output logic              err_double,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  logic              s1_valid_q, s1_valid_d;
  logic [CODE_W-1:0] s1_code_q, s1_code_d;
  logic [PAR_W-1:0]  s1_syn_q, s1_syn_d;
  logic              s1_perr_q, s1_perr_d;
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [PAR_W-1:0]  syn_q, syn_d;
  logic              err_single_q, err_single_d;
  logic              err_double_q, err_double_d;
  logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

  logic [PAR_W-1:0]  in_syn;
  logic              in_perr;
  logic              s2_adv;
  err_class_e        cls;
  logic [CODE_W-1:0] flip_mask;
  logic [CODE_W-1:0] code_corr;
  logic [DATA_W-1:0] data_ext;

  hamming_syndrome_calc #(
    .CODE_W (CODE_W),
    .PAR_W  (PAR_W)
  ) u_syn (
    .code     (code_in),
    .syndrome (in_syn),
    .p_err    (in_perr)
  );

  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;

  // Shortened codes can yield syndromes beyond the last position; those are uncorrectable.
  always_comb begin
    cls = DOUBLE;
    if (s1_syn_q == '0) begin
      cls = s1_perr_q ? PARITY_ONLY : CLEAN;
    end else if (s1_perr_q && int'(s1_syn_q) <= CODE_W - 1) begin
      cls = SINGLE;
    end
    flip_mask = '0;
    for (int i = 1; i < CODE_W; i++) begin
      if (cls == SINGLE && int'(s1_syn_q) == i) flip_mask[i] = 1'b1;
    end
    code_corr = s1_code_q ^ flip_mask;
  end

  for (genvar k = 0; k < DATA_W; k++) begin : g_ext
    localparam int POS = data_pos(k);
    assign data_ext[k] = code_corr[POS];
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_code_d    = s1_code_q;
    s1_syn_d     = s1_syn_q;
    s1_perr_d    = s1_perr_q;
    s2_valid_d   = s2_valid_q;
    data_d       = data_q;
    syn_d        = syn_q;
    err_single_d = err_single_q;
    err_double_d = err_double_q;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_code_d = code_in;
        s1_syn_d  = in_syn;
        s1_perr_d = in_perr;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        data_d       = data_ext;
        syn_d        = s1_syn_q;
        err_single_d = (cls == SINGLE) || (cls == PARITY_ONLY);
        err_double_d = (cls == DOUBLE);
      end
    end

    // Counting on the output handshake counts each word exactly once despite stalls.
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (s2_valid_q && out_ready) begin
      if (err_single_q && corr_cnt_q != '1)   corr_cnt_d   = corr_cnt_q + CNT_W'(1);
      if (err_double_q && uncorr_cnt_q != '1) uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_code_q    <= '0;
      s1_syn_q     <= '0;
      s1_perr_q    <= 1'b0;
      s2_valid_q   <= 1'b0;
      data_q       <= '0;
      syn_q        <= '0;
      err_single_q <= 1'b0;
      err_double_q <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_code_q    <= s1_code_d;
      s1_syn_q     <= s1_syn_d;
      s1_perr_q    <= s1_perr_d;
      s2_valid_q   <= s2_valid_d;
      data_q       <= data_d;
      syn_q        <= syn_d;
      err_single_q <= err_single_d;
      err_double_q <= err_double_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign data_out   = data_q;
  assign syndrome   = syn_q;
  assign err_single = err_single_q;
  assign err_double = err_double_q;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;

endmodule
